palette_write_ctrl: RTL and testbench



---
 rtl/ga_pkg.sv | 19 +
 rtl/palette_write_ctrl_if.sv | 9 +
 rtl/palette_write_ctrl_mode_latch.sv | 41 ++++
 rtl/palette_write_ctrl.sv | 124 ++++++++++++
 tb/tb_palette_write_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ga_pkg.sv
// Shared gate-array definitions: function codes, write-sequencer states, mode width.
package ga_pkg;

  localparam logic [1:0] FN_PEN  = 2'b00;
  localparam logic [1:0] FN_INK  = 2'b01;
  localparam logic [1:0] FN_MODE = 2'b10;
  localparam logic [1:0] FN_RSVD = 2'b11;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    COMMIT,
    ACK,
    WAIT_REL
  } wr_state_t;

endpackage

// File: rtl/palette_write_ctrl_if.sv
// CPU write handshake into the gate array: level request, data, one-cycle acknowledge.
interface palette_write_ctrl_if;
  logic       WR_REQ;
  logic [7:0] DATA;
  logic       WR_ACK;

  modport master (output WR_REQ, output DATA, input WR_ACK);
  modport slave  (input WR_REQ, input DATA, output WR_ACK);
endinterface

// File: rtl/palette_write_ctrl_mode_latch.sv
// Pending/active screen mode; the active mode is updated only on an HSYNC rising edge.
module ModeLatch
  import ga_pkg::*;
(
  input  logic              CLK_n,
  input  logic              RESET,
  input  logic              HSYNC,
  input  logic              commit_en,
  input  logic [MODE_W-1:0] commit_mode,
  output logic              MODE_IS_0,
  output logic              MODE_IS_2
);

  logic              hsync_q;
  logic [MODE_W-1:0] mode_pend;
  logic [MODE_W-1:0] mode_act;
  logic [MODE_W-1:0] pend_fwd;

  // A commit landing on the HSYNC edge is forwarded straight into the active mode.
  always_comb begin
    pend_fwd = commit_en ? commit_mode : mode_pend;
  end

  always_ff @(posedge CLK_n) begin
    if (RESET) begin
      hsync_q   <= 1'b0;
      mode_pend <= '0;
      mode_act  <= '0;
    end else begin
      hsync_q   <= HSYNC;
      mode_pend <= pend_fwd;
      if (HSYNC && !hsync_q) begin
        mode_act <= pend_fwd;
      end
    end
  end

  assign MODE_IS_0 = (mode_act == MODE_W'(0));
  assign MODE_IS_2 = (mode_act == MODE_W'(2));

endmodule

// File: rtl/palette_write_ctrl.sv
// Colour-mux register write sequencer: pen/border select, ink bit-planes, border, mode.
// Optional macro PALETTE_READBACK_EN adds the registered RD_PEN/RD_INK lookup port.
module palette_write_ctrl
  import ga_pkg::*;
(
  input  logic                       CLK_n,
  input  logic                       RESET,
  palette_write_ctrl_if.slave        bus,
  input  logic                       HSYNC,
  output logic [15:0]                INKR0,
  output logic [15:0]                INKR1,
  output logic [15:0]                INKR2,
  output logic [15:0]                INKR3,
  output logic [15:0]                INKR4,
  output logic [4:0]                 BORDER,
  output logic                       MODE_IS_0,
  output logic                       MODE_IS_2,
  output logic                       SEL_BORDER,
  output logic [3:0]                 PEN
`ifdef PALETTE_READBACK_EN
  ,
  input  logic [4:0]                 RD_PEN,
  output logic [4:0]                 RD_INK
`endif
);

  wr_state_t   state;
  wr_state_t   state_nxt;
  logic [7:0]  data_q;
  logic [15:0] ink [5];
  logic [1:0]  fn;
  logic        mode_commit;
  logic        unused_d5;

  assign fn          = data_q[7:6];
  assign mode_commit = (state == COMMIT) && (fn == FN_MODE);
  assign unused_d5   = data_q[5];

  always_ff @(posedge CLK_n) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.WR_REQ) state_nxt = LATCH;
      LATCH:    state_nxt = COMMIT;
      COMMIT:   state_nxt = ACK;
      ACK:      state_nxt = WAIT_REL;
      WAIT_REL: if (!bus.WR_REQ) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_n) begin
    if (RESET) begin
      data_q     <= '0;
      BORDER     <= '0;
      PEN        <= '0;
      SEL_BORDER <= 1'b0;
      bus.WR_ACK <= 1'b0;
      for (int unsigned n = 0; n < 5; n++) begin
        ink[n] <= '0;
      end
    end else begin
      bus.WR_ACK <= (state == ACK);
      if (state == LATCH) begin
        data_q <= bus.DATA;
      end
      if (state == COMMIT) begin
        case (fn)
          FN_PEN: begin
            SEL_BORDER <= data_q[4];
            if (!data_q[4]) PEN <= data_q[3:0];
          end
          FN_INK: begin
            if (SEL_BORDER) begin
              BORDER <= data_q[4:0];
            end else begin
              for (int unsigned n = 0; n < 5; n++) begin
                ink[n][PEN] <= data_q[n];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign INKR0 = ink[0];
  assign INKR1 = ink[1];
  assign INKR2 = ink[2];
  assign INKR3 = ink[3];
  assign INKR4 = ink[4];

  ModeLatch u_mode_latch (
    .CLK_n       (CLK_n),
    .RESET       (RESET),
    .HSYNC       (HSYNC),
    .commit_en   (mode_commit),
    .commit_mode (data_q[MODE_W-1:0]),
    .MODE_IS_0   (MODE_IS_0),
    .MODE_IS_2   (MODE_IS_2)
  );

`ifdef PALETTE_READBACK_EN
  always_ff @(posedge CLK_n) begin
    if (RESET) begin
      RD_INK <= '0;
    end else if (RD_PEN[4]) begin
      RD_INK <= BORDER;
    end else begin
      RD_INK <= {ink[4][RD_PEN[3:0]], ink[3][RD_PEN[3:0]], ink[2][RD_PEN[3:0]],
                 ink[1][RD_PEN[3:0]], ink[0][RD_PEN[3:0]]};
    end
  end
`endif

endmodule

// File: tb/tb_palette_write_ctrl.sv
// Directed bench for palette_write_ctrl: ink/border writes, mode timing, handshake, reset.
module tb_palette_write_ctrl;

  logic        CLK_n;
  logic        RESET;
  logic        HSYNC;
  logic [15:0] INKR0, INKR1, INKR2, INKR3, INKR4;
  logic [4:0]  BORDER;
  logic        MODE_IS_0, MODE_IS_2, SEL_BORDER;
  logic [3:0]  PEN;
`ifdef PALETTE_READBACK_EN
  logic [4:0]  RD_PEN;
  logic [4:0]  RD_INK;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int ack_at;
  int n_ack;
  logic [1:0] snap;

  palette_write_ctrl_if bus ();

  palette_write_ctrl dut (
    .CLK_n      (CLK_n),
    .RESET      (RESET),
    .bus        (bus),
    .HSYNC      (HSYNC),
    .INKR0      (INKR0),
    .INKR1      (INKR1),
    .INKR2      (INKR2),
    .INKR3      (INKR3),
    .INKR4      (INKR4),
    .BORDER     (BORDER),
    .MODE_IS_0  (MODE_IS_0),
    .MODE_IS_2  (MODE_IS_2),
    .SEL_BORDER (SEL_BORDER),
    .PEN        (PEN)
`ifdef PALETTE_READBACK_EN
    ,
    .RD_PEN     (RD_PEN),
    .RD_INK     (RD_INK)
`endif
  );

  initial CLK_n = 1'b0;
  always #5 CLK_n = ~CLK_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One write transaction. DATA is scrambled after the latch edge to prove it is ignored.
  // hold: minimum edges WR_REQ stays high; hs_edge: raise HSYNC after that edge (0 = never).
  // snap: {MODE_IS_0, MODE_IS_2} right after the commit edge.
  task automatic wr(input logic [7:0] d, input int hold, input int hs_edge,
                    output int ack_k, output int acks, output logic [1:0] mode_snap);
    ack_k = 0;
    acks  = 0;
    mode_snap = 2'b00;
    bus.WR_REQ = 1'b1;
    bus.DATA   = d;
    for (int k = 1; k <= 24; k++) begin
      @(posedge CLK_n); #1;
      if (k == 2) bus.DATA = ~d;
      if (k == 3) mode_snap = {MODE_IS_0, MODE_IS_2};
      if (k == hs_edge) HSYNC = 1'b1;
      if (bus.WR_ACK) begin
        acks++;
        if (ack_k == 0) ack_k = k;
      end
      if (ack_k != 0 && k >= hold) break;
    end
    bus.WR_REQ = 1'b0;
    HSYNC = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK_n); #1;
      if (bus.WR_ACK) acks++;
    end
  endtask

  initial begin
    RESET = 1'b1;
    HSYNC = 1'b0;
    bus.WR_REQ = 1'b0;
    bus.DATA   = 8'h00;
`ifdef PALETTE_READBACK_EN
    RD_PEN = 5'd0;
`endif
    repeat (3) @(posedge CLK_n);
    #1 RESET = 1'b0;

    check("rst_inkr0", INKR0, 0);
    check("rst_inkr4", INKR4, 0);
    check("rst_border", BORDER, 0);
    check("rst_mode0", MODE_IS_0, 1);
    check("rst_mode2", MODE_IS_2, 0);
    check("rst_ack", bus.WR_ACK, 0);

    wr(8'h05, 0, 0, ack_at, n_ack, snap);
    check("pen_sel", PEN, 5);
    check("pen_ack_lat", ack_at, 4);
    wr(8'h53, 0, 0, ack_at, n_ack, snap);
    check("ink_ack_lat", ack_at, 4);
    check("ink_ack_cnt", n_ack, 1);
    check("ink_r0", INKR0, 16'h0020);
    check("ink_r1", INKR1, 16'h0020);
    check("ink_r2", INKR2, 16'h0000);
    check("ink_r3", INKR3, 16'h0000);
    check("ink_r4", INKR4, 16'h0020);
`ifdef PALETTE_READBACK_EN
    RD_PEN = 5'd5;
    @(posedge CLK_n); #1;
    check("rd_pen5", RD_INK, 5'h13);
`endif

    wr(8'h0F, 0, 0, ack_at, n_ack, snap);
    wr(8'h4E, 0, 0, ack_at, n_ack, snap);
    check("pen15_r0", INKR0, 16'h0020);
    check("pen15_r1", INKR1, 16'h8020);
    check("pen15_r3", INKR3, 16'h8000);
    check("pen15_r4", INKR4, 16'h0020);

    wr(8'h10, 0, 0, ack_at, n_ack, snap);
    check("sel_border", SEL_BORDER, 1);
    wr(8'h4A, 0, 0, ack_at, n_ack, snap);
    check("border_val", BORDER, 5'h0A);
    check("border_r1", INKR1, 16'h8020);
    check("border_r2", INKR2, 16'h8000);
`ifdef PALETTE_READBACK_EN
    RD_PEN = 5'h10;
    @(posedge CLK_n); #1;
    check("rd_border", RD_INK, 5'h0A);
`endif

    wr(8'h82, 0, 0, ack_at, n_ack, snap);
    repeat (10) @(posedge CLK_n);
    #1;
    check("mode_wait0", MODE_IS_0, 1);
    check("mode_wait2", MODE_IS_2, 0);
    HSYNC = 1'b1;
    @(posedge CLK_n); #1;
    check("mode_hs0", MODE_IS_0, 0);
    check("mode_hs2", MODE_IS_2, 1);
    HSYNC = 1'b0;
    @(posedge CLK_n); #1;

    wr(8'hC3, 0, 0, ack_at, n_ack, snap);
    check("rsvd_ack", ack_at, 4);
    check("rsvd_border", BORDER, 5'h0A);
    check("rsvd_mode2", MODE_IS_2, 1);

    wr(8'h80, 0, 2, ack_at, n_ack, snap);
    check("fwd_mode0", snap, 2'b10);
    wr(8'h81, 0, 2, ack_at, n_ack, snap);
    check("fwd_mode1", snap, 2'b00);

    wr(8'h03, 8, 0, ack_at, n_ack, snap);
    check("hold_ack_cnt", n_ack, 1);
    check("hold_pen", PEN, 3);
    check("hold_sel", SEL_BORDER, 0);

    // Reset while in COMMIT with the request still held.
    bus.WR_REQ = 1'b1;
    bus.DATA   = 8'h4F;
    repeat (2) @(posedge CLK_n);
    #1 RESET = 1'b1;
    @(posedge CLK_n); #1;
    RESET = 1'b0;
    check("mid_inkr0", INKR0, 0);
    check("mid_border", BORDER, 0);
    check("mid_pen", PEN, 0);
    check("mid_mode0", MODE_IS_0, 1);
    check("mid_ack", bus.WR_ACK, 0);
    ack_at = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge CLK_n); #1;
      if (bus.WR_ACK && ack_at == 0) ack_at = k;
      if (ack_at != 0) break;
    end
    bus.WR_REQ = 1'b0;
    repeat (2) @(posedge CLK_n);
    #1;
    check("reaccept_lat", ack_at, 4);
    check("reaccept_r0", INKR0, 16'h0001);
    check("reaccept_r3", INKR3, 16'h0001);
    check("reaccept_r4", INKR4, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
